// File: rtl/fu_dispatch.sv
// fu_dispatch: single-entry dispatch register between issue/read-operands and
// execute. Holds one instruction, drives the shared operand bus and one valid
// strobe for the target unit, and blocks fixed-latency-unit writers that
// would collide with an in-flight multiplier result on the FLU writeback port.
// Optional build macro FU_DISPATCH_PERF_EN adds saturating stall counters
// (stall_struct_o, stall_coll_o).

package fu_dispatch_pkg;
  typedef enum logic [3:0] {
    NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR, FPU, FPU_VEC
  } fu_t;

  typedef struct packed {
    fu_t         fu;
    logic [7:0]  operation;
    logic [63:0] operand_a;
    logic [63:0] operand_b;
    logic [63:0] imm;
    logic [2:0]  trans_id;
  } fu_data_t;

  typedef struct packed {
    logic [1:0]  cf;
    logic [63:0] predict_address;
  } branchpredict_sbe_t;
endpackage

module fu_dispatch
  import fu_dispatch_pkg::*;
#(
  parameter int unsigned MULT_LAT = 1,
  parameter bit          FP_EN    = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  fu_data_t           issue_data_i,
  input  logic [63:0]        issue_pc_i,
  input  logic               issue_is_compressed_i,
  input  branchpredict_sbe_t issue_bp_i,
  output fu_data_t           fu_data_o,
  output logic [63:0]        pc_o,
  output logic               is_compressed_instr_o,
  output branchpredict_sbe_t branch_predict_o,
  output logic               alu_valid_o,
  output logic               branch_valid_o,
  output logic               csr_valid_o,
  output logic               mult_valid_o,
  output logic               lsu_valid_o,
  output logic               fpu_valid_o,
  input  logic               flu_ready_i,
  input  logic               lsu_ready_i,
  input  logic               fpu_ready_i,
  output logic               unsupported_o
`ifdef FU_DISPATCH_PERF_EN
  ,
  output logic [31:0]        stall_struct_o,
  output logic [31:0]        stall_coll_o
`endif
);

  logic                hold_q;
  logic [MULT_LAT-1:0] coll_q;

  logic is_alu, is_branch, is_csr, is_mult, is_lsu, is_fpu, is_none;
  logic is_flu, is_flu_wb;
  logic target_ready, collide, fire, drop, accept;

  // Decode the held instruction's functional-unit class
  always_comb begin
    is_alu    = 1'b0;
    is_branch = 1'b0;
    is_csr    = 1'b0;
    is_mult   = 1'b0;
    is_lsu    = 1'b0;
    is_fpu    = 1'b0;
    is_none   = 1'b0;
    unique case (fu_data_o.fu)
      ALU:          is_alu    = 1'b1;
      CTRL_FLOW:    is_branch = 1'b1;
      CSR:          is_csr    = 1'b1;
      MULT:         is_mult   = 1'b1;
      LOAD, STORE:  is_lsu    = 1'b1;
      FPU, FPU_VEC: is_fpu    = 1'b1;
      default:      is_none   = 1'b1;
    endcase
  end

  // Single-cycle FLU writers share the writeback port with the multiplier
  assign is_flu_wb = is_alu | is_branch | is_csr;
  assign is_flu    = is_flu_wb | is_mult;

  assign target_ready = (is_flu & flu_ready_i)
                      | (is_lsu & lsu_ready_i)
                      | (is_fpu & FP_EN & fpu_ready_i)
                      | is_none;

  assign collide = coll_q[0] & is_flu_wb;

  // Flush suppresses every strobe, so nothing can leave in the flush cycle
  assign fire   = hold_q & target_ready & ~collide & ~flush_i;
  assign drop   = hold_q & is_fpu & ~FP_EN & ~flush_i;
  assign accept = issue_valid_i & issue_ready_o;

  assign issue_ready_o = ~flush_i & (~hold_q | fire);

  assign alu_valid_o    = fire & is_alu;
  assign branch_valid_o = fire & is_branch;
  assign csr_valid_o    = fire & is_csr;
  assign mult_valid_o   = fire & is_mult;
  assign lsu_valid_o    = fire & is_lsu;
  assign fpu_valid_o    = fire & is_fpu;
  assign unsupported_o  = drop;

  // Occupancy of the holding register; a reload on fire keeps it full
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= 1'b0;
    end else if (flush_i) begin
      hold_q <= 1'b0;
    end else if (accept) begin
      hold_q <= 1'b1;
    end else if (fire | drop) begin
      hold_q <= 1'b0;
    end
  end

  // Payload of the holding register, visible to execute even when not firing
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fu_data_o             <= '0;
      pc_o                  <= '0;
      is_compressed_instr_o <= 1'b0;
      branch_predict_o      <= '0;
    end else if (accept) begin
      fu_data_o             <= issue_data_i;
      pc_o                  <= issue_pc_i;
      is_compressed_instr_o <= issue_is_compressed_i;
      branch_predict_o      <= issue_bp_i;
    end
  end

  // Multiplier writeback tracker: entry 0 marks the cycle the port is taken
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      coll_q <= '0;
    end else if (flush_i) begin
      coll_q <= '0;
    end else begin
      for (int i = 0; i < int'(MULT_LAT) - 1; i++) begin
        coll_q[i] <= coll_q[i+1];
      end
      coll_q[MULT_LAT-1] <= mult_valid_o;
    end
  end

`ifdef FU_DISPATCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Stall accounting; counts survive flushes and clear only on reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_struct_o <= '0;
      stall_coll_o   <= '0;
    end else begin
      if (hold_q & ~target_ready) begin
        stall_struct_o <= sat_inc(stall_struct_o);
      end
      if (hold_q & target_ready & collide) begin
        stall_coll_o <= sat_inc(stall_coll_o);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fu_dispatch.sv
// Testbench for fu_dispatch: directed stimulus with a scoreboard of expected
// dispatch events (unit, trans_id, cycle) checked by an independent monitor.
// A second instance built with FP_EN=0 covers the absent-FPU path.

module tb_fu_dispatch;
  import fu_dispatch_pkg::*;

  localparam int K_ALU = 1, K_BR = 2, K_CSR = 3, K_MULT = 4, K_LSU = 5, K_FPU = 6, K_UNS = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic issue_valid = 1'b0;
  fu_data_t issue_data;
  logic [63:0] issue_pc;
  logic issue_c;
  branchpredict_sbe_t issue_bp;
  logic flu_ready = 1'b1, lsu_ready = 1'b1, fpu_ready = 1'b1;

  logic a_ready, a_comp, a_alu, a_br, a_csr, a_mult, a_lsu, a_fpu, a_uns;
  fu_data_t a_data;
  logic [63:0] a_pc;
  branchpredict_sbe_t a_bp;
  logic b_ready, b_comp, b_alu, b_br, b_csr, b_mult, b_lsu, b_fpu, b_uns;
  fu_data_t b_data;
  logic [63:0] b_pc;
  branchpredict_sbe_t b_bp;
`ifdef FU_DISPATCH_PERF_EN
  logic [31:0] a_sstruct, a_scoll, b_sstruct, b_scoll;
`endif

  fu_dispatch #(.MULT_LAT(1), .FP_EN(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_ready_o(a_ready),
    .issue_data_i(issue_data), .issue_pc_i(issue_pc),
    .issue_is_compressed_i(issue_c), .issue_bp_i(issue_bp),
    .fu_data_o(a_data), .pc_o(a_pc), .is_compressed_instr_o(a_comp),
    .branch_predict_o(a_bp),
    .alu_valid_o(a_alu), .branch_valid_o(a_br), .csr_valid_o(a_csr),
    .mult_valid_o(a_mult), .lsu_valid_o(a_lsu), .fpu_valid_o(a_fpu),
    .flu_ready_i(flu_ready), .lsu_ready_i(lsu_ready), .fpu_ready_i(fpu_ready),
    .unsupported_o(a_uns)
`ifdef FU_DISPATCH_PERF_EN
    , .stall_struct_o(a_sstruct), .stall_coll_o(a_scoll)
`endif
  );

  fu_dispatch #(.MULT_LAT(1), .FP_EN(1'b0)) dut_nofp (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_ready_o(b_ready),
    .issue_data_i(issue_data), .issue_pc_i(issue_pc),
    .issue_is_compressed_i(issue_c), .issue_bp_i(issue_bp),
    .fu_data_o(b_data), .pc_o(b_pc), .is_compressed_instr_o(b_comp),
    .branch_predict_o(b_bp),
    .alu_valid_o(b_alu), .branch_valid_o(b_br), .csr_valid_o(b_csr),
    .mult_valid_o(b_mult), .lsu_valid_o(b_lsu), .fpu_valid_o(b_fpu),
    .flu_ready_i(flu_ready), .lsu_ready_i(lsu_ready), .fpu_ready_i(fpu_ready),
    .unsupported_o(b_uns)
`ifdef FU_DISPATCH_PERF_EN
    , .stall_struct_o(b_sstruct), .stall_coll_o(b_scoll)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    logic [2:0] tid;
    int         at;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(fu_t fu, logic [2:0] tid);
    issue_valid = 1'b1;
    issue_data = '0;
    issue_data.fu = fu;
    issue_data.trans_id = tid;
    issue_data.operand_a = 64'h100 + 64'(tid);
    issue_pc = 64'h1000 + 64'(tid) * 64'd4;
    issue_c = tid[0];
    issue_bp = '0;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
  endtask

  task automatic expect_ev(int kind, logic [2:0] tid, int at);
    exp_t e;
    e.kind = kind;
    e.tid = tid;
    e.at = at;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe on the main instance must match the next expectation
  always @(negedge clk) begin : monitor
    int nstb, kind;
    exp_t e;
    if (rst_n) begin
      nstb = int'(a_alu) + int'(a_br) + int'(a_csr) + int'(a_mult) + int'(a_lsu)
           + int'(a_fpu) + int'(a_uns);
      kind = a_alu ? K_ALU : a_br ? K_BR : a_csr ? K_CSR : a_mult ? K_MULT :
             a_lsu ? K_LSU : a_fpu ? K_FPU : a_uns ? K_UNS : 0;
      if (nstb > 1) begin
        n_checks++;
        $display("FAIL one_strobe: got %0d strobes at cycle %0d expected 1", nstb, cyc);
      end
      if (nstb != 0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL dispatch: got kind %0d tid %0d cycle %0d expected no strobe",
                   kind, a_data.trans_id, cyc);
        end else begin
          e = exp_q.pop_front();
          if (kind == e.kind && a_data.trans_id == e.tid && cyc == e.at) n_pass++;
          else $display("FAIL dispatch: got kind %0d tid %0d cycle %0d expected kind %0d tid %0d cycle %0d",
                        kind, a_data.trans_id, cyc, e.kind, e.tid, e.at);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef FU_DISPATCH_PERF_EN
    logic [31:0] s0, c0;
`endif
    issue_data = '0;
    issue_pc = '0;
    issue_c = 1'b0;
    issue_bp = '0;

    // reset state
    #2;
    check("reset_ready", 64'(a_ready), 64'd1);
    check("reset_strobes", 64'({a_alu, a_br, a_csr, a_mult, a_lsu, a_fpu}), 64'd0);
    check("reset_unsupported", 64'(a_uns), 64'd0);
    check("reset_fu_data", 64'(a_data == '0), 64'd1);
    check("reset_pc", a_pc, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // four ALU ops back-to-back, one per cycle
    for (int i = 0; i < 4; i++) begin
      drive(ALU, 3'(i));
      expect_ev(K_ALU, 3'(i), cyc + 1);
      #1;
      check("alu_stream_ready", 64'(a_ready), 64'd1);
      if (i > 0) check("alu_stream_pc", a_pc, 64'h1000 + 64'(i - 1) * 64'd4);
      tick();
    end
    idle();
    tick();

    // branch, CSR, NONE (silent slot), ALU back-to-back
    drive(CTRL_FLOW, 3'd4); expect_ev(K_BR, 3'd4, cyc + 1); tick();
    drive(CSR, 3'd5);       expect_ev(K_CSR, 3'd5, cyc + 1); tick();
    drive(NONE, 3'd6);      tick();
    drive(ALU, 3'd7);       expect_ev(K_ALU, 3'd7, cyc + 1);
    #1;
    check("none_slot_ready", 64'(a_ready), 64'd1);
    tick();
    idle();
    tick();
`ifdef FU_DISPATCH_PERF_EN
    s0 = a_sstruct;
    c0 = a_scoll;
`endif

    // MULT then ALU: the ALU is held off one cycle by the writeback collision
    drive(MULT, 3'd1); expect_ev(K_MULT, 3'd1, cyc + 1); tick();
    drive(ALU, 3'd2);  expect_ev(K_ALU, 3'd2, cyc + 2);
    #1;
    check("mult_fire_ready", 64'(a_ready), 64'd1);
    tick();
    idle();
    #1;
    check("collide_ready", 64'(a_ready), 64'd0);
    check("collide_alu_low", 64'(a_alu), 64'd0);
    tick();
    idle();
    tick();

    // MULT then LOAD: the LSU is not blocked
    drive(MULT, 3'd3); expect_ev(K_MULT, 3'd3, cyc + 1); tick();
    drive(LOAD, 3'd4); expect_ev(K_LSU, 3'd4, cyc + 1); tick();
    idle();
    tick();

    // LOAD stalled three cycles by lsu_ready
    lsu_ready = 1'b0;
    drive(LOAD, 3'd5); expect_ev(K_LSU, 3'd5, cyc + 4); tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lsu_stall_ready", 64'(a_ready), 64'd0);
      check("lsu_stall_tid", 64'(a_data.trans_id), 64'd5);
      tick();
    end
    lsu_ready = 1'b1;
    #1;
    check("lsu_release_ready", 64'(a_ready), 64'd1);
    tick();
`ifdef FU_DISPATCH_PERF_EN
    check("perf_struct", 64'(a_sstruct - s0), 64'd3);
    check("perf_coll", 64'(a_scoll - c0), 64'd1);
`endif

    // flush a stalled STORE while a collision is pending; ALU fires right after
    drive(MULT, 3'd6); expect_ev(K_MULT, 3'd6, cyc + 1); tick();
    drive(STORE, 3'd7);
    lsu_ready = 1'b0;
    tick();
    idle();
    flush = 1'b1;
    #1;
    check("flush_ready", 64'(a_ready), 64'd0);
    tick();
    flush = 1'b0;
    lsu_ready = 1'b1;
    drive(ALU, 3'd0); expect_ev(K_ALU, 3'd0, cyc + 1);
    #1;
    check("post_flush_ready", 64'(a_ready), 64'd1);
    tick();
    idle();
    tick();

    // FPU op: dispatched on the FP instance, reported unsupported without FP
    drive(FPU, 3'd3); expect_ev(K_FPU, 3'd3, cyc + 1); tick();
    idle();
    #1;
    check("nofp_unsupported", 64'(b_uns), 64'd1);
    check("nofp_fpu_valid", 64'(b_fpu), 64'd0);
    check("nofp_ready_busy", 64'(b_ready), 64'd0);
    tick();
    drive(ALU, 3'd4); expect_ev(K_ALU, 3'd4, cyc + 1);
    #1;
    check("nofp_unsupported_pulse", 64'(b_uns), 64'd0);
    check("nofp_ready_after_drop", 64'(b_ready), 64'd1);
    tick();
    idle();
    #1;
    check("nofp_next_alu", 64'(b_alu), 64'd1);
    check("nofp_next_tid", 64'(b_data.trans_id), 64'd4);
    tick();

    // asynchronous reset while a LOAD is held
    lsu_ready = 1'b0;
    drive(LOAD, 3'd2); tick();
    idle();
    #1;
    check("held_ready", 64'(a_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("async_rst_ready", 64'(a_ready), 64'd1);
    check("async_rst_pc", a_pc, 64'd0);
    check("async_rst_data", 64'(a_data == '0), 64'd1);
`ifdef FU_DISPATCH_PERF_EN
    check("async_rst_perf", 64'({a_sstruct, a_scoll}), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    lsu_ready = 1'b1;
    tick();
    tick();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
